// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Index/counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request strictly after 'last', wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]                req,
  input  logic [clog2_min1(N)-1:0]    last,
  output logic                        any,
  output logic [clog2_min1(N)-1:0]    idx
);

  localparam int unsigned IDW = clog2_min1(N);

  int unsigned cand;

  // Scan from farthest to nearest so the nearest hit after 'last' wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int k = N; k >= 1; k--) begin
      cand = (32'(last) + 32'(k)) % N;
      if (req[IDW'(cand)]) begin
        any = 1'b1;
        idx = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited sharing of the async FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_w_full,
  output logic                            fifo_w_en,
  output logic [DATA_WIDTH-1:0]           fifo_w_data,
  output logic                            grant_active,
  output logic [clog2_min1(NUM_REQ)-1:0]  grant_id
);

  localparam int unsigned IDW = clog2_min1(NUM_REQ);
  localparam int unsigned BCW = clog2_min1(MAX_BURST);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);

  arb_state_e     state, state_d;
  logic [IDW-1:0] grant_id_d;
  logic [IDW-1:0] last_grant, last_grant_d;
  logic [BCW-1:0] beat_cnt, beat_cnt_d;
  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic           acc;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (req_valid),
    .last (last_grant),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Write port is driven straight from the granted requester; rst_n gates acceptance.
  assign grant_active = (state == ARB_GRANT);
  assign acc          = grant_active & req_valid[grant_id] & ~fifo_w_full & rst_n;
  assign fifo_w_en    = acc;
  assign fifo_w_data  = req_data[32'(grant_id)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_ready[i] = grant_active & (grant_id == IDW'(i)) & ~fifo_w_full & rst_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      grant_id   <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_d;
      grant_id   <= grant_id_d;
      last_grant <= last_grant_d;
      beat_cnt   <= beat_cnt_d;
    end
  end

  // Full holds the grant indefinitely; only burst end or a dropped valid releases it.
  always_comb begin
    state_d      = state;
    grant_id_d   = grant_id;
    last_grant_d = last_grant;
    beat_cnt_d   = beat_cnt;
    unique case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
          state_d    = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (acc) begin
          if (beat_cnt == LAST_BEAT) begin
            last_grant_d = grant_id;
            state_d      = ARB_IDLE;
          end else begin
            beat_cnt_d = beat_cnt + BCW'(1);
          end
        end else if (!req_valid[grant_id]) begin
          last_grant_d = grant_id;
          state_d      = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences and a random run against a reference model.
module tb_fifo_wr_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned MB  = 4;
  localparam int unsigned IDW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              fifo_w_full;
  logic              fifo_w_en;
  logic [DW-1:0]     fifo_w_data;
  logic              grant_active;
  logic [IDW-1:0]    grant_id;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_w_full  (fifo_w_full),
    .fifo_w_en    (fifo_w_en),
    .fifo_w_data  (fifo_w_data),
    .grant_active (grant_active),
    .grant_id     (grant_id)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the port, who released last, beats done in this grant.
  bit m_ok    = 1'b0;
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_last  = N - 1;
  int m_beats = 0;
  int dut_writes   = 0;
  int model_writes = 0;
  logic [DW-1:0] wq[$];

  typedef struct {
    logic [N-1:0]   valid;
    logic [DW-1:0]  d2;
    logic           full;
    logic           en;
    logic [DW-1:0]  wdata;
    logic [N-1:0]   ready;
    logic           active;
    logic [IDW-1:0] gid;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] dut_obs();
    return {fifo_w_en, fifo_w_en ? fifo_w_data : 8'h00, req_ready, grant_active, grant_id};
  endfunction

  function automatic logic [15:0] model_exp();
    logic [N-1:0]  rdy;
    logic          en;
    logic [DW-1:0] d;
    rdy = '0;
    for (int i = 0; i < int'(N); i++)
      rdy[i] = m_busy && (i == m_owner) && !fifo_w_full && rst_n;
    en = rdy[m_owner] & req_valid[m_owner];
    d  = req_data[m_owner*DW +: DW];
    return {en, en ? d : 8'h00, rdy, m_busy, IDW'(m_owner)};
  endfunction

  task automatic expect_out(input string name, input logic en, input logic [DW-1:0] d,
                            input logic [N-1:0] rdy, input logic act, input logic [IDW-1:0] gid);
    check(name, 32'(dut_obs()), 32'({en, en ? d : 8'h00, rdy, act, gid}));
  endtask

  // Compare against the model, advance the model, then cross the clock edge.
  task automatic tick();
    logic [15:0] e;
    if (m_ok) begin
      e = model_exp();
      check("model", 32'(dut_obs()), 32'(e));
      if (fifo_w_en) begin
        dut_writes++;
        wq.push_back(fifo_w_data);
      end
      if (e[15]) model_writes++;
    end
    if (!rst_n) begin
      m_ok = 1'b1; m_busy = 1'b0; m_owner = 0; m_last = N - 1; m_beats = 0;
    end else if (m_ok) begin
      if (!m_busy) begin
        for (int k = 1; k <= int'(N); k++) begin
          if (!m_busy && req_valid[(m_last + k) % N]) begin
            m_busy = 1'b1; m_owner = (m_last + k) % N; m_beats = 0;
          end
        end
      end else if (e[15]) begin
        m_beats++;
        if (m_beats == MB) begin m_busy = 1'b0; m_last = m_owner; end
      end else if (!req_valid[m_owner]) begin
        m_busy = 1'b0; m_last = m_owner;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] v);
    rst_n = 1'b0; req_valid = v; fifo_w_full = 1'b0;
    #1; tick();
    #1; tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] acc_s;

    // Reset held with every requester asking.
    rst_n = 1'b0; req_valid = 4'b1111; fifo_w_full = 1'b0;
    req_data = {8'h33, 8'h22, 8'h11, 8'h00};
    #1; tick();
    check("t1_rst_en_ready", 32'({fifo_w_en, req_ready}), 32'd0);
    check("t1_rst_active", 32'(grant_active), 32'd0);
    #1; tick();
    check("t1_rst_en_ready2", 32'({fifo_w_en, req_ready}), 32'd0);
    rst_n = 1'b1;
    #1; expect_out("t1_release_idle", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
    tick();
    #1; expect_out("t1_first_grant", 1'b1, 8'h00, 4'b0001, 1'b1, 2'd0);
    tick();

    // Requester 2 alone: burst of four, bubble, regrant for the last two.
    tbl[0] = '{4'b0100, 8'h10, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
    tbl[1] = '{4'b0100, 8'h10, 1'b0, 1'b1, 8'h10, 4'b0100, 1'b1, 2'd2};
    tbl[2] = '{4'b0100, 8'h11, 1'b0, 1'b1, 8'h11, 4'b0100, 1'b1, 2'd2};
    tbl[3] = '{4'b0100, 8'h12, 1'b0, 1'b1, 8'h12, 4'b0100, 1'b1, 2'd2};
    tbl[4] = '{4'b0100, 8'h13, 1'b0, 1'b1, 8'h13, 4'b0100, 1'b1, 2'd2};
    tbl[5] = '{4'b0100, 8'h14, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2};
    tbl[6] = '{4'b0100, 8'h14, 1'b0, 1'b1, 8'h14, 4'b0100, 1'b1, 2'd2};
    tbl[7] = '{4'b0100, 8'h15, 1'b0, 1'b1, 8'h15, 4'b0100, 1'b1, 2'd2};
    tbl[8] = '{4'b0000, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0100, 1'b1, 2'd2};
    tbl[9] = '{4'b0000, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2};
    do_reset(4'b0000);
    wq.delete();
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].valid;
      req_data  = {8'h00, tbl[i].d2, 16'h0000};
      fifo_w_full = tbl[i].full;
      #1;
      expect_out($sformatf("t2_row%0d", i), tbl[i].en, tbl[i].wdata, tbl[i].ready,
                 tbl[i].active, tbl[i].gid);
      tick();
    end
    check("t2_write_count", 32'(wq.size()), 32'd6);
    for (int k = 0; k < 6 && k < wq.size(); k++)
      check($sformatf("t2_order%0d", k), 32'(wq[k]), 32'(8'h10 + k));

    // All four contending: 0,1,2,3,0 with four beats each and one bubble between.
    do_reset(4'b1111);
    req_data = {8'h33, 8'h22, 8'h11, 8'h00};
    for (int c = 0; c < 26; c++) begin
      int g;
      #1;
      if (c % 5 == 0) begin
        g = (c == 0) ? 0 : ((c / 5) - 1) % 4;
        expect_out($sformatf("t3_bubble_c%0d", c), 1'b0, 8'h00, 4'b0000, 1'b0, IDW'(g));
      end else begin
        g = (c / 5) % 4;
        expect_out($sformatf("t3_beat_c%0d", c), 1'b1, 8'(g * 17), 4'(1 << g), 1'b1, IDW'(g));
      end
      tick();
    end

    // Requester 1 stalled by full for five cycles after its second beat.
    do_reset(4'b0000);
    req_valid = 4'b0010; req_data = {16'h0000, 8'hA0, 8'h00};
    #1; expect_out("t4_idle", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0); tick();
    #1; expect_out("t4_beat0", 1'b1, 8'hA0, 4'b0010, 1'b1, 2'd1); tick();
    req_data[15:8] = 8'hA1;
    #1; expect_out("t4_beat1", 1'b1, 8'hA1, 4'b0010, 1'b1, 2'd1); tick();
    req_data[15:8] = 8'hA2; fifo_w_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1; expect_out($sformatf("t4_full%0d", c), 1'b0, 8'h00, 4'b0000, 1'b1, 2'd1); tick();
    end
    fifo_w_full = 1'b0;
    #1; expect_out("t4_beat2", 1'b1, 8'hA2, 4'b0010, 1'b1, 2'd1); tick();
    req_data[15:8] = 8'hA3;
    #1; expect_out("t4_beat3", 1'b1, 8'hA3, 4'b0010, 1'b1, 2'd1); tick();
    #1; expect_out("t4_released", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1);
    req_valid = 4'b0000; tick();

    // Requester 3 drops valid after one beat; requester 0 then wins over 3.
    do_reset(4'b0000);
    req_valid = 4'b1000; req_data = {8'h30, 16'h0000, 8'h05};
    #1; tick();
    #1; expect_out("t5_beat", 1'b1, 8'h30, 4'b1000, 1'b1, 2'd3); tick();
    req_valid = 4'b0001;
    #1; expect_out("t5_drop", 1'b0, 8'h00, 4'b1000, 1'b1, 2'd3); tick();
    req_valid = 4'b1001;
    #1; expect_out("t5_bubble", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd3); tick();
    #1; expect_out("t5_next_grant", 1'b1, 8'h05, 4'b0001, 1'b1, 2'd0); tick();

    // Reset in the middle of requester 1's burst.
    do_reset(4'b0000);
    req_valid = 4'b0010; req_data = {16'h0000, 8'h40, 8'h00};
    #1; tick(); #1; tick(); #1; tick();
    rst_n = 1'b0; req_valid = 4'b1111;
    #1; check("t6_rst_mid_en_ready", 32'({fifo_w_en, req_ready}), 32'd0); tick();
    #1; check("t6_rst_en_ready", 32'({fifo_w_en, req_ready}), 32'd0);
    check("t6_rst_active", 32'(grant_active), 32'd0); tick();
    rst_n = 1'b1; req_valid = 4'b0110;
    #1; expect_out("t6_after_idle", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0); tick();
    #1; expect_out("t6_after_grant", 1'b1, 8'h40, 4'b0010, 1'b1, 2'd1); tick();

    // Random traffic against the reference model.
    do_reset(4'b0000);
    req_valid = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      #1;
      acc_s = req_valid & req_ready;
      tick();
      for (int i = 0; i < int'(N); i++) begin
        if (acc_s[i]) begin
          req_valid[i] = ($urandom % 2) != 0;
          req_data[i*DW +: DW] = 8'($urandom);
        end else if (req_valid[i]) begin
          if ($urandom % 40 == 0) req_valid[i] = 1'b0;
        end else if ($urandom % 3 == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = 8'($urandom);
        end
      end
      fifo_w_full = ($urandom % 4) == 0;
      rst_n = ($urandom % 300) != 0;
    end
    rst_n = 1'b1;
    #1; tick();
    check("total_writes", 32'(dut_writes), 32'(model_writes));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
